// File: rtl/encrypt_arbiter_if.sv
// Requester and result-port handshake bundle for encrypt_arbiter.
// master = requesters/consumers side, slave = arbiter side.
interface encrypt_arbiter_if;
    logic       a_valid;
    logic [7:0] a_data;
    logic       a_last;
    logic       a_ready;
    logic       b_valid;
    logic [7:0] b_data;
    logic       b_last;
    logic       b_ready;
    logic       ya_valid;
    logic [7:0] ya_data;
    logic       ya_last;
    logic       ya_ready;
    logic       yb_valid;
    logic [7:0] yb_data;
    logic       yb_last;
    logic       yb_ready;

    modport master (
        output a_valid, a_data, a_last, b_valid, b_data, b_last, ya_ready, yb_ready,
        input  a_ready, b_ready, ya_valid, ya_data, ya_last, yb_valid, yb_data, yb_last
    );

    modport slave (
        input  a_valid, a_data, a_last, b_valid, b_data, b_last, ya_ready, yb_ready,
        output a_ready, b_ready, ya_valid, ya_data, ya_last, yb_valid, yb_data, yb_last
    );
endinterface

// File: rtl/encrypt_arbiter.sv
// Two-port arbiter sharing one encrypt_unit: burst grants, tagged in-flight tracking
// through the engine latency, and credit-guarded per-port result FIFOs.
module encrypt_arbiter #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned MAX_BURST  = 8,
    parameter int unsigned ENC_LAT    = 2
) (
    input  logic             clk,
    input  logic             rst,
    encrypt_arbiter_if.slave bus,
    output logic             enc_en,
    output logic [7:0]       enc_din,
    input  logic [7:0]       enc_dout,
    input  logic             enc_v,
    output logic             err
);
    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned PW = AW + 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {StIdle, StOwnA, StOwnB} state_e;

    state_e        state_q, state_d;
    logic          rr_q, rr_d;  // 0 = A next, 1 = B next
    logic [7:0]    burst_q, burst_d;
    logic [CW-1:0] credit_q [2];
    logic [CW-1:0] credit_d [2];
    logic [ENC_LAT-1:0] tag_v_q, tag_p_q, tag_l_q;
    logic [8:0]    mem_q [2][FIFO_DEPTH];
    logic [PW-1:0] wr_q [2];
    logic [PW-1:0] rd_q [2];
    logic          err_q;

    logic       owner, own_valid, own_last, own_ready, xfer, push;
    logic [7:0] own_data;
    logic [1:0] xfer_p, push_p, pop, y_valid, y_ready;
    logic [8:0] y_head [2];

    always_comb begin
        owner     = (state_q == StOwnB);
        own_valid = owner ? bus.b_valid : bus.a_valid;
        own_data  = owner ? bus.b_data  : bus.a_data;
        own_last  = owner ? bus.b_last  : bus.a_last;
        own_ready = (state_q != StIdle) && (credit_q[owner] != '0);
        xfer      = own_valid && own_ready;
        xfer_p    = {xfer && owner, xfer && !owner};
    end

    assign bus.a_ready = own_ready && (state_q == StOwnA);
    assign bus.b_ready = own_ready && (state_q == StOwnB);
    assign enc_en      = xfer;
    assign enc_din     = xfer ? own_data : 8'h00;

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        burst_d = burst_q;
        unique case (state_q)
            StIdle: begin
                burst_d = '0;
                if (bus.a_valid && bus.b_valid) state_d = rr_q ? StOwnB : StOwnA;
                else if (bus.a_valid)           state_d = StOwnA;
                else if (bus.b_valid)           state_d = StOwnB;
            end
            StOwnA, StOwnB: begin
                if (!own_valid) begin
                    state_d = StIdle;
                    rr_d    = !owner;
                end else if (xfer) begin
                    burst_d = burst_q + 8'd1;
                    if (own_last || (burst_d == 8'(MAX_BURST))) begin
                        state_d = StIdle;
                        rr_d    = !owner;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Result FIFO status and credit bookkeeping, one lane per port.
    assign y_ready = {bus.yb_ready, bus.ya_ready};

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            y_valid[i]  = (wr_q[i] != rd_q[i]);
            pop[i]      = y_valid[i] && y_ready[i];
            y_head[i]   = y_valid[i] ? mem_q[i][rd_q[i][AW-1:0]] : 9'h000;
            credit_d[i] = credit_q[i];
            if (xfer_p[i] && !pop[i])      credit_d[i] = credit_q[i] - CW'(1);
            else if (pop[i] && !xfer_p[i]) credit_d[i] = credit_q[i] + CW'(1);
        end
    end

    assign push   = tag_v_q[ENC_LAT-1] && enc_v;
    assign push_p = {push && tag_p_q[ENC_LAT-1], push && !tag_p_q[ENC_LAT-1]};

    assign bus.ya_valid = y_valid[0];
    assign bus.ya_data  = y_head[0][7:0];
    assign bus.ya_last  = y_head[0][8];
    assign bus.yb_valid = y_valid[1];
    assign bus.yb_data  = y_head[1][7:0];
    assign bus.yb_last  = y_head[1][8];
    assign err          = err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            rr_q    <= 1'b0;
            burst_q <= '0;
            err_q   <= 1'b0;
            tag_v_q <= '0;
            tag_p_q <= '0;
            tag_l_q <= '0;
            for (int i = 0; i < 2; i++) begin
                credit_q[i] <= CW'(FIFO_DEPTH);
                wr_q[i]     <= '0;
                rd_q[i]     <= '0;
                for (int j = 0; j < FIFO_DEPTH; j++) mem_q[i][j] <= '0;
            end
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            burst_q <= burst_d;
            // Any disagreement between engine and tag stream is a protocol fault.
            err_q   <= err_q || (enc_v != tag_v_q[ENC_LAT-1]);
            tag_v_q[0] <= xfer;
            tag_p_q[0] <= owner;
            tag_l_q[0] <= own_last;
            for (int k = 1; k < ENC_LAT; k++) begin
                tag_v_q[k] <= tag_v_q[k-1];
                tag_p_q[k] <= tag_p_q[k-1];
                tag_l_q[k] <= tag_l_q[k-1];
            end
            for (int i = 0; i < 2; i++) begin
                credit_q[i] <= credit_d[i];
                if (push_p[i]) begin
                    mem_q[i][wr_q[i][AW-1:0]] <= {tag_l_q[ENC_LAT-1], enc_dout};
                    wr_q[i] <= wr_q[i] + PW'(1);
                end
                if (pop[i]) rd_q[i] <= rd_q[i] + PW'(1);
            end
        end
    end
endmodule
